// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external, purely combinational yAlu between two requesters.
// A registered round-robin arbiter picks a winner in IDLE, latches that
// requester's operands, drives the ALU for one cycle (EXEC), captures the
// result into response registers and presents it (RESP) until the consumer
// accepts it. Only one transaction is ever in flight.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                          undefined -> round-robin on ties (default)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req0/req1             requester wants an ALU op
//   a0,b0,op0 / a1,b1,op1 requester operands and op code (stable while req)
//   gnt0/gnt1             one-cycle pulse during EXEC: request accepted
//   alu_a, alu_b, alu_op  to yAlu
//   alu_z, alu_ex         from yAlu (result, zero flag)
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                requester owning the response
//   rsp_z, rsp_ex, rsp_err result, zero flag, unsupported-op flag
//   dbg_state_o           current FSM state, for observation only
//
// Handshake: a response transfers on a rising edge where rsp_valid and
// rsp_ready are both 1. rsp_valid never drops and rsp_id/rsp_z/rsp_ex/rsp_err
// never change while rsp_valid is 1 and rsp_ready is 0.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [2:0]   op0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    input  logic [2:0]   op1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_z,
    input  logic         alu_ex,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_z,
    output logic         rsp_ex,
    output logic         rsp_err,
    input  logic         rsp_ready,
    output logic [1:0]   dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic         last_id_q, last_id_d;
    logic         id_q, id_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic         rsp_id_q, rsp_id_d;
    logic [W-1:0] rsp_z_q, rsp_z_d;
    logic         rsp_ex_q, rsp_ex_d;
    logic         rsp_err_q, rsp_err_d;

    logic         win;
    logic         op_ok;

    // Winner among the currently raised requests (meaningful only when at
    // least one request is high).
    always_comb begin
        win = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        win = ~req0;
`else
        // On a tie the requester not granted most recently wins.
        if (req0 && req1) begin
            win = ~last_id_q;
        end else begin
            win = req1;
        end
`endif
    end

    // Op codes the ALU defines a result for.
    always_comb begin
        op_ok = 1'b0;
        case (op_q)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_ok = 1'b1;
            default:                                 op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        last_id_d = last_id_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rsp_id_d  = rsp_id_q;
        rsp_z_d   = rsp_z_q;
        rsp_ex_d  = rsp_ex_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    id_d      = win;
                    last_id_d = win;
                    a_d       = win ? a1  : a0;
                    b_d       = win ? b1  : b0;
                    op_d      = win ? op1 : op0;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                // Unsupported ops still go to the ALU, but its output is
                // replaced with a defined zero result.
                rsp_id_d  = id_q;
                rsp_z_d   = op_ok ? alu_z  : '0;
                rsp_ex_d  = op_ok ? alu_ex : 1'b1;
                rsp_err_d = ~op_ok;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_id_q <= 1'b1;
            id_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 3'b000;
            rsp_id_q  <= 1'b0;
            rsp_z_q   <= '0;
            rsp_ex_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_id_q <= last_id_d;
            id_q      <= id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rsp_id_q  <= rsp_id_d;
            rsp_z_q   <= rsp_z_d;
            rsp_ex_q  <= rsp_ex_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Grants are decoded from registered state, so they are glitch-free,
    // mutually exclusive and last exactly the one EXEC cycle.
    assign gnt0        = (state_q == S_EXEC) && !id_q;
    assign gnt1        = (state_q == S_EXEC) &&  id_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_z       = rsp_z_q;
    assign rsp_ex      = rsp_ex_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   op0, op1;
    logic         gnt0, gnt1;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_z;
    logic         alu_ex;
    logic         rsp_valid, rsp_id, rsp_ex, rsp_err, rsp_ready;
    logic [W-1:0] rsp_z;
    logic [1:0]   dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- stand-in for the external yAlu ----------------
    always_comb begin
        alu_z = '0;
        case (alu_op)
            3'b000:  alu_z = alu_a & alu_b;
            3'b001:  alu_z = alu_a | alu_b;
            3'b010:  alu_z = alu_a + alu_b;
            3'b110:  alu_z = alu_a - alu_b;
            3'b111:  alu_z = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_z = alu_a ^ ~alu_b;  // junk the arbiter must mask
        endcase
        alu_ex = (alu_z == '0);
    end

    alu_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .op0(op0),
        .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_z(alu_z), .alu_ex(alu_ex),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
        .rsp_ex(rsp_ex), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           pend[2];
    logic [W-1:0] pa[2];
    logic [W-1:0] pb[2];
    logic [2:0]   pop[2];
    bit           last_id;

    // Returns {err, ex, z} for one operation.
    function automatic logic [W+1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        logic [W-1:0] z;
        bit err;
        z = '0;
        err = 0;
        case (op)
            3'd0: z = a & b;
            3'd1: z = a | b;
            3'd2: z = W'(a + b);
            3'd6: z = W'(a - b);
            3'd7: z = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: err = 1;
        endcase
        if (err) return {1'b1, 1'b1, {W{1'b0}}};
        return {1'b0, (z == '0), z};
    endfunction

    function automatic bit pick(input bit p0, input bit p1, input bit last);
        if (p0 && p1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !last;
`endif
        end
        return p1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_reqs();
        req0 = pend[0]; a0 = pa[0]; b0 = pb[0]; op0 = pop[0];
        req1 = pend[1]; a1 = pa[1]; b1 = pb[1]; op1 = pop[1];
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        pend[id] = 1; pa[id] = a; pb[id] = b; pop[id] = op;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, gnt0, 0);
        check({tag, "_gnt1"}, gnt1, 0);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_op"}, alu_op, 0);
        check({tag, "_valid"}, rsp_valid, 0);
        check({tag, "_id"}, rsp_id, 0);
        check({tag, "_z"}, rsp_z, 0);
        check({tag, "_ex"}, rsp_ex, 0);
        check({tag, "_err"}, rsp_err, 0);
    endtask

    // Called at a negedge with the DUT idle and at least one request pending.
    // Runs one full transaction, stalling the response for 'stall' cycles.
    // With keep=1 the winner keeps its request raised afterwards.
    task automatic serve(input int stall, input bit keep);
        bit w;
        logic [W+1:0] r;
        logic [W-1:0] ez;
        w = pick(pend[0], pend[1], last_id);
        r = ref_alu(pa[w], pb[w], pop[w]);
        exp_q.push_back(r[W-1:0]);
        drive_reqs();
        rsp_ready = 0;
        @(negedge clk);
        check("gnt0", gnt0, (w == 0));
        check("gnt1", gnt1, (w == 1));
        check("valid_in_exec", rsp_valid, 0);
        check("alu_a", alu_a, pa[w]);
        check("alu_b", alu_b, pb[w]);
        check("alu_op", alu_op, pop[w]);
        if (!keep) begin
            pend[w] = 0;
            drive_reqs();
        end
        @(negedge clk);
        ez = exp_q.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, w);
        check("rsp_z", rsp_z, ez);
        check("rsp_ex", rsp_ex, r[W]);
        check("rsp_err", rsp_err, r[W+1]);
        check("gnt_in_resp", {gnt1, gnt0}, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", rsp_valid, 1);
            check("stall_id", rsp_id, w);
            check("stall_z", rsp_z, ez);
            check("stall_ex", rsp_ex, r[W]);
            check("stall_err", rsp_err, r[W+1]);
            check("stall_gnt", {gnt1, gnt0}, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        check("idle_valid", rsp_valid, 0);
        check("idle_gnt", {gnt1, gnt0}, 0);
        last_id = w;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b0, {(W-1){1'b1}}};
            2: return {1'b1, {(W-1){1'b0}}};
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst = 1; rsp_ready = 0;
        pend[0] = 0; pend[1] = 0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; pop[0] = '0; pop[1] = '0;
        drive_reqs();
        last_id = 1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        // Basic transactions and boundaries.
        set_req(0, 5, 7, 3'b010);
        serve(0, 0);
        set_req(1, 9, 9, 3'b110);
        serve(0, 0);
        set_req(0, 32'h7FFF_FFFF, 1, 3'b010);
        serve(0, 0);
        set_req(0, 3, 4, 3'b011);
        serve(0, 0);
        set_req(1, 32'hFFFF_FFFF, 1, 3'b111);
        serve(0, 0);

        // Both requests held high with rsp_ready=1.
        set_req(0, W'($urandom), W'($urandom), 3'b000);
        set_req(1, W'($urandom), W'($urandom), 3'b001);
        for (int i = 0; i < 4; i++) serve(0, 1);
        pend[0] = 0; pend[1] = 0;
        drive_reqs();

        // Backpressure: response held 5 cycles, loser granted right after.
        set_req(0, 100, 58, 3'b110);
        set_req(1, 6, 10, 3'b000);
        serve(5, 0);
        serve(0, 0);

        // Reset during EXEC, with requests high across the reset.
        set_req(0, 11, 22, 3'b010);
        set_req(1, 33, 44, 3'b010);
        drive_reqs();
        @(negedge clk);
        check("pre_rst_gnt", {gnt1, gnt0}, pick(1, 1, last_id) ? 2'b10 : 2'b01);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("rst_exec");
        @(negedge clk);
        check("rst_req_gnt", {gnt1, gnt0}, 0);
        check("rst_req_valid", rsp_valid, 0);
        rst = 0;
        last_id = 1;
        serve(0, 0);
        serve(0, 0);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pend[id] && ($urandom_range(0, 2) != 0))
                    set_req(id, rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
            end
            if (!pend[0] && !pend[1])
                set_req($urandom_range(0, 1), rand_operand(), rand_operand(),
                        3'($urandom_range(0, 7)));
            serve($urandom_range(0, 3), 0);
        end
        pend[0] = 0; pend[1] = 0;
        drive_reqs();
        @(negedge clk);
        check("final_idle_gnt", {gnt1, gnt0}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
